// File: rtl/max_pool_2x2.sv
// max_pool_2x2: non-overlapping 2x2 pooling over a CHxIN_HxIN_W Q8.8 map.
// Define POOL_AVG_EN to build average pooling instead of max pooling.
module max_pool_2x2 #(
    parameter int          CH       = 2,
    parameter int          IN_H     = 8,
    parameter int          IN_W     = 8,
    parameter logic [15:0] IN_BASE  = 16'd256,
    parameter logic [15:0] OUT_BASE = 16'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] rd_data,
    output logic [15:0] rd_addr,
    output logic        we,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        pool_end
);

    localparam int HO    = IN_H / 2;
    localparam int WO    = IN_W / 2;
    localparam int N_OUT = CH * HO * WO;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int RW    = (HO > 1) ? $clog2(HO) : 1;
    localparam int PW    = (WO > 1) ? $clog2(WO) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAST,
        S_WR,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_k;
    logic [CW-1:0]   r_c;
    logic [RW-1:0]   r_pr;
    logic [PW-1:0]   r_pc;
    logic [15:0]     r_o;
    logic [15:0]     r_rd_addr;
    logic [15:0]     r_wr_addr;
    logic [15:0]     r_wr_data;
    logic [15:0]     w_elem_addr;
    logic [15:0]     w_result;
    logic            w_last_win;
`ifdef POOL_AVG_EN
    logic signed [17:0] r_acc;
`else
    logic [15:0]        r_acc;
`endif

    assign w_last_win = (r_o == 16'(N_OUT - 1));

    // Address of window element k for the current (c, pr, pc)
    always_comb begin
        w_elem_addr = 16'(32'(IN_BASE)
                    + 32'(r_c) * 32'(IN_H * IN_W)
                    + (32'(r_pr) * 32'd2 + 32'(r_k[1])) * 32'(IN_W)
                    + 32'(r_pc) * 32'd2
                    + 32'(r_k[0]));
`ifdef POOL_AVG_EN
        w_result = 16'(r_acc >>> 2);
`else
        w_result = r_acc;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        rd_addr  = r_rd_addr;
        we       = 1'b0;
        wr_addr  = r_wr_addr;
        wr_data  = r_wr_data;
        pool_end = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_RD;
            S_RD: begin
                rd_addr = w_elem_addr;
                if (r_k == 2'd3) w_next = S_LAST;
            end
            S_LAST: w_next = S_WR;
            S_WR: begin
                we      = 1'b1;
                wr_addr = OUT_BASE + r_o;
                wr_data = w_result;
                w_next  = w_last_win ? S_DONE : S_RD;
            end
            S_DONE: pool_end = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (!enable) w_next = S_IDLE;
    end

    // Element and window counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k  <= '0;
            r_c  <= '0;
            r_pr <= '0;
            r_pc <= '0;
            r_o  <= '0;
        end else if (!enable) begin
            r_k  <= '0;
            r_c  <= '0;
            r_pr <= '0;
            r_pc <= '0;
            r_o  <= '0;
        end else if (r_state == S_RD) begin
            r_k <= r_k + 2'd1;
        end else if (r_state == S_WR && !w_last_win) begin
            r_k <= '0;
            r_o <= r_o + 16'd1;
            if (r_pc == PW'(WO - 1)) begin
                r_pc <= '0;
                if (r_pr == RW'(HO - 1)) begin
                    r_pr <= '0;
                    r_c  <= r_c + 1'b1;
                end else begin
                    r_pr <= r_pr + 1'b1;
                end
            end else begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    // Accumulate the element returned for the previous read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (enable &&
                     ((r_state == S_RD && r_k != 2'd0) ||
                      r_state == S_LAST)) begin
`ifdef POOL_AVG_EN
            if (r_state == S_RD && r_k == 2'd1)
                r_acc <= {{2{rd_data[15]}}, rd_data};
            else
                r_acc <= r_acc + {{2{rd_data[15]}}, rd_data};
`else
            if ((r_state == S_RD && r_k == 2'd1) ||
                ($signed(rd_data) > $signed(r_acc)))
                r_acc <= rd_data;
`endif
        end
    end

    // Hold the last read address and last written word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (r_state == S_RD) r_rd_addr <= w_elem_addr;
            if (r_state == S_WR) begin
                r_wr_addr <= OUT_BASE + r_o;
                r_wr_data <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: randomized self-checking bench for max_pool_2x2.
// Reference pooling is computed directly from the memory image.
module tb_max_pool_2x2;

    localparam int          CH       = 2;
    localparam int          IN_H     = 8;
    localparam int          IN_W     = 8;
    localparam logic [15:0] IN_BASE  = 16'd256;
    localparam logic [15:0] OUT_BASE = 16'd1;
    localparam int          HO       = IN_H / 2;
    localparam int          WO       = IN_W / 2;
    localparam int          N_OUT    = CH * HO * WO;
    localparam int          N_IN     = CH * IN_H * IN_W;
    localparam int          T_END    = 6 * N_OUT + 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] rd_data;
    logic [15:0] rd_addr;
    logic        we;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        pool_end;

    logic [15:0] mem [65536];
    logic [15:0] ref_q [N_OUT];
    logic [31:0] wq [$];
    int vectors = 0;
    int miscompares = 0;

    max_pool_2x2 #(
        .CH(CH), .IN_H(IN_H), .IN_W(IN_W),
        .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .rd_data(rd_data), .rd_addr(rd_addr), .we(we),
        .wr_addr(wr_addr), .wr_data(wr_data), .pool_end(pool_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) if (we) wq.push_back({wr_addr, wr_data});

    task automatic build_ref();
        for (int o = 0; o < N_OUT; o++) begin
            int c, pr, pc, s;
            logic signed [15:0] v, m;
            c = o / (HO * WO);
            pr = (o % (HO * WO)) / WO;
            pc = o % WO;
            s = 0;
            m = '0;
            for (int k = 0; k < 4; k++) begin
                v = mem[16'(int'(IN_BASE) + c * IN_H * IN_W
                       + (2 * pr + k / 2) * IN_W + 2 * pc + k % 2)];
                if (k == 0 || v > m) m = v;
                s += 32'(v);
            end
`ifdef POOL_AVG_EN
            ref_q[o] = 16'(s >>> 2);
`else
            ref_q[o] = m;
`endif
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_IN; i++)
            mem[16'(int'(IN_BASE) + i)] = 16'($urandom);
    endtask

    task automatic do_pass(output int cyc);
        enable = 1'b0;
        @(negedge clk);
        wq.delete();
        enable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pool_end && cyc < 400);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rd_addr, wr_addr, wr_data} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_addr_data got %h/%h/%h want 0",
                     rd_addr, wr_addr, wr_data);
        end
        vectors++;
        if ({we, pool_end} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags got we=%b end=%b want 0",
                     we, pool_end);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int cyc;
        for (int i = 0; i < N_IN; i++)
            mem[16'(int'(IN_BASE) + i)] = 16'(i);
        build_ref();
        do_pass(cyc);
        vectors++;
        if (cyc != T_END) begin
            miscompares++;
            $display("FAIL ramp_end_cycle got %0d want %0d", cyc, T_END);
        end
        vectors++;
        if (wq.size() != N_OUT) begin
            miscompares++;
            $display("FAIL ramp_count got %0d want %0d", wq.size(), N_OUT);
        end
        for (int i = 0; i < wq.size() && i < N_OUT; i++) begin
            vectors++;
            if (wq[i] !== {OUT_BASE + 16'(i), ref_q[i]}) begin
                miscompares++;
                $display("FAIL ramp_word%0d got %h want %h", i, wq[i],
                         {OUT_BASE + 16'(i), ref_q[i]});
            end
        end
`ifndef POOL_AVG_EN
        if (wq.size() > 16) begin
            vectors++;
            if (wq[0][15:0] !== 16'd9 || wq[16][15:0] !== 16'd73) begin
                miscompares++;
                $display("FAIL ramp_known got %0d,%0d want 9,73",
                         wq[0][15:0], wq[16][15:0]);
            end
        end
`endif
    endtask

    task automatic test_hold();
        logic [15:0] ra;
        int n;
        ra = rd_addr;
        n = wq.size();
        repeat (8) begin
            @(negedge clk);
            vectors++;
            if (we !== 1'b0 || pool_end !== 1'b1 || rd_addr !== ra) begin
                miscompares++;
                $display("FAIL hold got we=%b end=%b ra=%h want 0,1,%h",
                         we, pool_end, rd_addr, ra);
            end
        end
        vectors++;
        if (wq.size() != n) begin
            miscompares++;
            $display("FAIL hold_writes got %0d want %0d", wq.size(), n);
        end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (pool_end !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_clear got %b want 0", pool_end);
        end
    endtask

    task automatic test_random();
        int cyc;
        repeat (2) begin
            fill_random();
            build_ref();
            do_pass(cyc);
            vectors++;
            if (cyc != T_END || wq.size() != N_OUT) begin
                miscompares++;
                $display("FAIL rand_pass got cyc=%0d n=%0d want %0d,%0d",
                         cyc, wq.size(), T_END, N_OUT);
            end
            for (int i = 0; i < wq.size() && i < N_OUT; i++) begin
                vectors++;
                if (wq[i] !== {OUT_BASE + 16'(i), ref_q[i]}) begin
                    miscompares++;
                    $display("FAIL rand_word%0d got %h want %h", i, wq[i],
                             {OUT_BASE + 16'(i), ref_q[i]});
                end
            end
        end
    endtask

    task automatic test_windows();
        int cyc;
        logic [15:0] w [2][4];
        w[0] = '{16'h8000, 16'hFF00, 16'hFF80, 16'hFFFF};
        w[1] = '{16'h0100, 16'h0100, 16'h0080, 16'h0100};
        for (int t = 0; t < 2; t++) begin
            fill_random();
            mem[IN_BASE]                = w[t][0];
            mem[IN_BASE + 16'd1]        = w[t][1];
            mem[IN_BASE + 16'(IN_W)]    = w[t][2];
            mem[IN_BASE + 16'(IN_W + 1)] = w[t][3];
            build_ref();
            do_pass(cyc);
            vectors++;
            if (wq.size() != N_OUT || cyc != T_END) begin
                miscompares++;
                $display("FAIL win%0d_pass got n=%0d cyc=%0d", t,
                         wq.size(), cyc);
            end else begin
                vectors++;
                if (wq[0] !== {OUT_BASE, ref_q[0]} ||
                    wq[1][31:16] !== OUT_BASE + 16'd1) begin
                    miscompares++;
                    $display("FAIL win%0d_word got %h want %h", t, wq[0],
                             {OUT_BASE, ref_q[0]});
                end
`ifndef POOL_AVG_EN
                vectors++;
                if (wq[0][15:0] !== (t == 0 ? 16'hFFFF : 16'h0100)) begin
                    miscompares++;
                    $display("FAIL win%0d_max got %h", t, wq[0][15:0]);
                end
`endif
            end
        end
    endtask

    task automatic test_abort();
        int cyc;
        fill_random();
        build_ref();
        enable = 1'b0;
        @(negedge clk);
        wq.delete();
        enable = 1'b1;
        repeat (32) @(negedge clk);
        vectors++;
        if (rd_addr !== IN_BASE + 16'd2 * 16'(IN_W) + 16'd3) begin
            miscompares++;
            $display("FAIL abort_rdaddr got %h want %h", rd_addr,
                     IN_BASE + 16'd2 * 16'(IN_W) + 16'd3);
        end
        enable = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (we !== 1'b0 || pool_end !== 1'b0 || wq.size() != 5) begin
            miscompares++;
            $display("FAIL abort got we=%b end=%b n=%0d want 0,0,5",
                     we, pool_end, wq.size());
        end
        do_pass(cyc);
        vectors++;
        if (cyc != T_END || wq.size() != N_OUT) begin
            miscompares++;
            $display("FAIL abort_restart got cyc=%0d n=%0d", cyc,
                     wq.size());
        end
        for (int i = 0; i < wq.size() && i < N_OUT; i++) begin
            vectors++;
            if (wq[i] !== {OUT_BASE + 16'(i), ref_q[i]}) begin
                miscompares++;
                $display("FAIL abort_word%0d got %h want %h", i, wq[i],
                         {OUT_BASE + 16'(i), ref_q[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill_random();
        build_ref();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (24) @(negedge clk);
        vectors++;
        if (we !== 1'b1 || wr_addr !== OUT_BASE + 16'd3) begin
            miscompares++;
            $display("FAIL rstmid_wr got we=%b addr=%h want 1,%h",
                     we, wr_addr, OUT_BASE + 16'd3);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({we, pool_end, rd_addr, wr_addr, wr_data} !== 50'd0) begin
            miscompares++;
            $display("FAIL rstmid_async got we=%b %h %h %h", we,
                     rd_addr, wr_addr, wr_data);
        end
        @(negedge clk);
        wq.delete();
        reset_n = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pool_end && cyc < 400);
        vectors++;
        if (cyc != T_END || wq.size() != N_OUT) begin
            miscompares++;
            $display("FAIL rstmid_pass got cyc=%0d n=%0d", cyc, wq.size());
        end
        for (int i = 0; i < wq.size() && i < N_OUT; i++) begin
            vectors++;
            if (wq[i] !== {OUT_BASE + 16'(i), ref_q[i]}) begin
                miscompares++;
                $display("FAIL rstmid_word%0d got %h want %h", i, wq[i],
                         {OUT_BASE + 16'(i), ref_q[i]});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        test_reset();
        test_ramp();
        test_hold();
        test_random();
        test_windows();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
